// File: rtl/sqrt_datapath.sv
// sqrt_datapath: datapath for the iterative integer square-root unit.
// Odd-number summation: sq walks 1, 4, 9, ... while del walks 3, 5, 7, ...;
// the root is recovered from del once sq overshoots the radicand.
//
// Ports:
//   clk       system clock, rising edge
//   clr_n     synchronous active-low reset
//   din       radicand, sampled on ald
//   ald       load radicand, initialise iteration registers (highest priority)
//   sqld      sq <= sq + del
//   dld       del <= del + 2
//   outld     capture root from del
//   lteflg    combinational sq <= a (unsigned)
//   root      result register
//   root_vld  root holds the result for the current radicand
//   iter      accepted sqld count since last ald (saturating)
//   err       sticky protocol error (only with SQRT_PROTO_CHK_EN, else 0)
//
// Optional feature macro: SQRT_PROTO_CHK_EN
module sqrt_datapath #(
    parameter  int unsigned W  = 8,
    localparam int unsigned RW = W / 2
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [W-1:0]  din,
    input  logic          ald,
    input  logic          sqld,
    input  logic          dld,
    input  logic          outld,
    output logic          lteflg,
    output logic [RW-1:0] root,
    output logic          root_vld,
    output logic [RW:0]   iter,
    output logic          err
);

    // sq holds the overshoot (root+1)^2 <= 2^W; del ends at most 2^(RW+1)+1
    localparam int unsigned SQW = W + 1;
    localparam int unsigned DW  = RW + 2;
    localparam int unsigned IW  = RW + 1;

    logic [W-1:0]   a;
    logic [SQW-1:0] sq;
    logic [DW-1:0]  del;

    // Comparison flag back to the controller
    assign lteflg = (sq <= SQW'(a));

    // Iteration registers and result capture
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            a        <= '0;
            sq       <= SQW'(1);
            del      <= DW'(3);
            root     <= '0;
            root_vld <= 1'b0;
            iter     <= '0;
        end else if (ald) begin
            a        <= din;
            sq       <= SQW'(1);
            del      <= DW'(3);
            iter     <= '0;
            root_vld <= 1'b0;
        end else begin
            if (sqld) begin
                sq <= sq + SQW'(del);
                if (iter != {IW{1'b1}}) begin
                    iter <= iter + IW'(1);
                end
            end
            if (dld) begin
                del <= del + DW'(2);
            end
            // del = 2*root + 3 at this point, so root = del/2 - 1
            if (outld) begin
                root     <= RW'((del >> 1) - DW'(1));
                root_vld <= 1'b1;
            end
        end
    end

`ifdef SQRT_PROTO_CHK_EN
    logic proto_viol_c;

    // Illegal strobe combinations seen by this edge
    always_comb begin
        proto_viol_c = 1'b0;
        if (sqld != dld)                     proto_viol_c = 1'b1;
        if (ald && (sqld || dld || outld))   proto_viol_c = 1'b1;
        if (sqld && !lteflg)                 proto_viol_c = 1'b1;
        if (outld && lteflg)                 proto_viol_c = 1'b1;
    end

    // Sticky error flag; does not gate the datapath updates
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            err <= 1'b0;
        end else if (proto_viol_c) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_datapath.sv
// Self-checking bench for sqrt_datapath: a legal controller is emulated in
// the bench; expectations come from an integer square-root reference model.
module tb_sqrt_datapath;

    localparam int unsigned W  = 8;
    localparam int unsigned RW = W / 2;

    logic          clk;
    logic          clr_n;
    logic [W-1:0]  din;
    logic          ald;
    logic          sqld;
    logic          dld;
    logic          outld;
    logic          lteflg;
    logic [RW-1:0] root;
    logic          root_vld;
    logic [RW:0]   iter;
    logic          err;

    int total = 0;
    int bad   = 0;
    int exp_root = 0;
    int exp_err  = 0;

    sqrt_datapath #(.W(W)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .din      (din),
        .ald      (ald),
        .sqld     (sqld),
        .dld      (dld),
        .outld    (outld),
        .lteflg   (lteflg),
        .root     (root),
        .root_vld (root_vld),
        .iter     (iter),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: largest r with r*r <= n
    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        exp_root = 0;
        exp_err  = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_lteflg"},   int'(lteflg),   0);
        check_val({tag, "_root"},     int'(root),     0);
        check_val({tag, "_root_vld"}, int'(root_vld), 0);
        check_val({tag, "_iter"},     int'(iter),     0);
        check_val({tag, "_err"},      int'(err),      0);
    endtask

    task automatic load(input int n);
        din = W'(n);
        ald = 1'b1;
        tick();
        ald = 1'b0;
        check_val("ald_root_vld", int'(root_vld), 0);
        check_val("ald_root_hold", int'(root), exp_root);
        check_val("ald_iter", int'(iter), 0);
    endtask

    task automatic update();
        sqld = 1'b1;
        dld  = 1'b1;
        tick();
        sqld = 1'b0;
        dld  = 1'b0;
    endtask

    // Full legal sequence for radicand n
    task automatic run_sqrt(input int n);
        int k = 0;
        int r;
        r = isqrt(n);
        load(n);
        while (lteflg && k < 40) begin
            // after k updates sq=(k+1)^2
            check_val("step_lteflg", int'(lteflg), ((k + 1) * (k + 1) <= n) ? 1 : 0);
            update();
            k++;
        end
        check_val("updates", k, r);
        check_val("iter", int'(iter), r);
        check_val("final_lteflg", int'(lteflg), 0);
        outld = 1'b1;
        tick();
        outld = 1'b0;
        exp_root = r;
        check_val("root", int'(root), r);
        check_val("root_vld", int'(root_vld), 1);
        check_val("err_legal", int'(err), exp_err);
    endtask

    initial begin
        clr_n = 1'b1;
        din   = '0;
        ald   = 1'b0;
        sqld  = 1'b0;
        dld   = 1'b0;
        outld = 1'b0;
        tick();
        do_reset();
        check_reset_state("reset");

        // Directed cases
        run_sqrt(0);
        run_sqrt(64);
        // Repeated outld is idempotent
        outld = 1'b1;
        tick();
        tick();
        outld = 1'b0;
        check_val("idem_root", int'(root), 8);
        check_val("idem_vld", int'(root_vld), 1);
        // Reload drops valid but keeps previous root
        run_sqrt(9);
        run_sqrt(63);
        run_sqrt(255);
        run_sqrt(1);
        run_sqrt(3);
        run_sqrt(4);

        // Randomized radicands
        for (int i = 0; i < 30; i++) begin
            run_sqrt(int'($urandom_range(0, 255)));
        end

        // Reset in the middle of an update sequence
        run_sqrt(200);
        load(200);
        update();
        update();
        update();
        clr_n = 1'b0;
        sqld  = 1'b1;
        dld   = 1'b1;
        outld = 1'b1;
        tick();
        clr_n = 1'b1;
        sqld  = 1'b0;
        dld   = 1'b0;
        outld = 1'b0;
        exp_root = 0;
        exp_err  = 0;
        check_reset_state("midreset");

        // Simultaneous sqld+dld+outld: root from pre-edge del
        load(255);
        update();
        update();
        update();
        sqld  = 1'b1;
        dld   = 1'b1;
        outld = 1'b1;
        tick();
        sqld  = 1'b0;
        dld   = 1'b0;
        outld = 1'b0;
        check_val("simul_root", int'(root), 3);
        check_val("simul_vld", int'(root_vld), 1);
        check_val("simul_iter", int'(iter), 4);
        check_val("simul_lteflg", int'(lteflg), 1);
`ifdef SQRT_PROTO_CHK_EN
        exp_err = 1;
`endif
        check_val("simul_err", int'(err), exp_err);
        do_reset();
        check_reset_state("reset2");

        // ald priority over other strobes
        run_sqrt(100);
        din   = W'(50);
        ald   = 1'b1;
        sqld  = 1'b1;
        dld   = 1'b1;
        outld = 1'b1;
        tick();
        ald   = 1'b0;
        sqld  = 1'b0;
        dld   = 1'b0;
        outld = 1'b0;
        check_val("prio_root", int'(root), 10);
        check_val("prio_vld", int'(root_vld), 0);
        check_val("prio_iter", int'(iter), 0);
        check_val("prio_lteflg", int'(lteflg), 1);
        do_reset();

        // Protocol error: sqld without dld, sticky across ald
        sqld = 1'b1;
        tick();
        sqld = 1'b0;
`ifdef SQRT_PROTO_CHK_EN
        exp_err = 1;
`endif
        check_val("perr_set", int'(err), exp_err);
        run_sqrt(16);
        check_val("perr_sticky", int'(err), exp_err);
        do_reset();
        check_val("perr_clear", int'(err), 0);
        run_sqrt(225);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
